// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stable-count debounce, and press/release/long-press pulses.
// Optional auto-repeat pulse is enabled with the BUTTON_REPEAT_EN macro; REPEAT_PULSE is tied 0 otherwise.
`timescale 1ns/1ps

module button_debouncer #(
  parameter bit          ACTIVE_LOW        = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES   = 480000,
  parameter int unsigned LONG_PRESS_CYCLES = 48000000,
  parameter int unsigned REPEAT_CYCLES     = 9600000
) (
  input  logic CLK_48,
  input  logic RST_N,
  input  logic BTN,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LONG_PULSE,
  output logic REPEAT_PULSE
);

  localparam int unsigned STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic              IDLE_LVL  = ACTIVE_LOW;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_LONG_HELD,
    S_REL_WAIT
  } state_e;

  logic              sync1_q, sync2_q;
  logic              p;
  state_e            state_q, state_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              from_long_q, from_long_d;
  logic              pressed_q, pressed_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // The synchroniser idles at the released level so a button held through reset debounces as a fresh press.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= BTN;
      sync2_q <= sync1_q;
    end
  end

  assign p        = sync2_q ^ ACTIVE_LOW;
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    stab_d      = stab_q;
    hold_d      = hold_q;
    from_long_d = from_long_q;
    pressed_d   = pressed_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        pressed_d = 1'b0;
        stab_d    = '0;
        if (p) begin
          state_d = S_PRESS_WAIT;
          stab_d  = STAB_ONE;
        end
      end
      S_PRESS_WAIT: begin
        if (!p) begin
          state_d = S_IDLE;
          stab_d  = '0;
        end else if (stab_q == STAB_MAX) begin
          state_d     = S_HELD;
          stab_d      = '0;
          hold_d      = '0;
          from_long_d = 1'b0;
          pressed_d   = 1'b1;
          press_d     = 1'b1;
        end else begin
          stab_d = stab_q + STAB_ONE;
        end
      end
      S_HELD: begin
        if (!p) begin
          state_d = S_REL_WAIT;
          stab_d  = STAB_ONE;
        end else begin
          hold_d = hold_inc;
          if (hold_q == HOLD_LAST) begin
            state_d     = S_LONG_HELD;
            from_long_d = 1'b1;
            long_d      = 1'b1;
          end
        end
      end
      S_LONG_HELD: begin
        if (!p) begin
          state_d = S_REL_WAIT;
          stab_d  = STAB_ONE;
        end else begin
          hold_d = hold_inc;
        end
      end
      S_REL_WAIT: begin
        // Hold time is frozen here; a bounce back resumes whichever held state we left.
        if (p) begin
          state_d = from_long_q ? S_LONG_HELD : S_HELD;
          stab_d  = '0;
        end else if (stab_q == STAB_MAX) begin
          state_d   = S_IDLE;
          stab_d    = '0;
          pressed_d = 1'b0;
          release_d = 1'b1;
        end else begin
          stab_d = stab_q + STAB_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        stab_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      stab_q      <= '0;
      hold_q      <= '0;
      from_long_q <= 1'b0;
      pressed_q   <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_q      <= stab_d;
      hold_q      <= hold_d;
      from_long_q <= from_long_d;
      pressed_q   <= pressed_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign PRESSED       = pressed_q;
  assign PRESS_PULSE   = press_q;
  assign RELEASE_PULSE = release_q;
  assign LONG_PULSE    = long_q;

`ifdef BUTTON_REPEAT_EN
  localparam int unsigned       REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic             enter_long;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_pulse_q, rep_pulse_d;

  // Only a fresh HELD->LONG_HELD entry restarts the period; bounce-back re-entry keeps the count.
  assign enter_long = (state_q == S_HELD) && (state_d == S_LONG_HELD);

  always_comb begin
    rep_d       = rep_q;
    rep_pulse_d = 1'b0;
    if (enter_long) begin
      rep_d = '0;
    end else if ((state_q == S_LONG_HELD) && p) begin
      if (rep_q == REP_LAST) begin
        rep_d       = '0;
        rep_pulse_d = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      rep_q       <= '0;
      rep_pulse_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end

  assign REPEAT_PULSE = rep_pulse_q;
`else
  assign REPEAT_PULSE = 1'b0;
`endif

endmodule
